// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one registered full-adder cell walks the operands
// LSB-first, then holds sum/cout/ovf until the consumer takes them.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic w_a;
  logic w_b;
  logic w_s;
  logic w_c;

  // Operands shift right each step, so bit 0 is always the bit at r_idx.
  assign w_a = r_a[0];
  assign w_b = r_b[0];
  assign w_s = w_a ^ w_b ^ r_carry;
  assign w_c = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= carry_in;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
          end else begin
            r_sum[r_idx] <= w_s;
            r_carry      <= w_c;
            r_a          <= r_a >> 1;
            r_b          <= r_b >> 1;
            if (r_idx == IDX_LAST) begin
              r_cout  <= w_c;
              // r_carry here is the carry into the MSB
              r_ovf   <= r_carry ^ w_c;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
          end else if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign res_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       carry_in;
  logic       abort;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the controller idle; hold cycles of res_ready=0.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec,
                         input logic eo, input int hold);
    op_a = a; op_b = b; carry_in = cin; in_valid = 1'b1;
    check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val({tag, ".busy"}, 32'(busy), 32'd1);
      check_val({tag, ".early_valid"}, 32'(res_valid), 32'd0);
      step();
    end
    check_val({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    check_val({tag, ".busy_done"}, 32'(busy), 32'd0);
    check_val({tag, ".sum"}, 32'(sum), 32'(es));
    check_val({tag, ".cout"}, 32'(cout), 32'(ec));
    check_val({tag, ".ovf"}, 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      step();
      check_val({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
      check_val({tag, ".hold_sum"}, 32'(sum), 32'(es));
      check_val({tag, ".hold_cout"}, 32'(cout), 32'(ec));
      check_val({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_val({tag, ".back_idle"}, 32'(in_ready), 32'd1);
    check_val({tag, ".valid_drop"}, 32'(res_valid), 32'd0);
    $display("add %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d", tag, a, b, cin, sum, cout, ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_res;
    int second_res;
    rstn = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
    abort = 1'b0; res_ready = 1'b0;

    // Reset held, then released
    @(negedge clk);
    check_val("rst.in_ready", 32'(in_ready), 32'd1);
    check_val("rst.res_valid", 32'(res_valid), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    step();
    rstn = 1'b1;
    step();
    check_val("post_rst.in_ready", 32'(in_ready), 32'd1);
    check_val("post_rst.res_valid", 32'(res_valid), 32'd0);
    check_val("post_rst.busy", 32'(busy), 32'd0);
    check_val("post_rst.sum", 32'(sum), 32'h00);
    check_val("post_rst.cout", 32'(cout), 32'd0);
    check_val("post_rst.ovf", 32'(ovf), 32'd0);
    $display("reset: in_ready=%0d res_valid=%0d busy=%0d sum=%02h", in_ready, res_valid, busy, sum);

    run_add("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
    run_add("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_add("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_add("addff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 5);

    // Stray in_valid with other operands during RUN must be ignored
    op_a = 8'h0F; op_b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        op_a = 8'hF0; op_b = 8'hF0; carry_in = 1'b1; in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      check_val("ignore.busy", 32'(busy), 32'd1);
      step();
    end
    check_val("ignore.res_valid", 32'(res_valid), 32'd1);
    check_val("ignore.sum", 32'(sum), 32'h10);
    check_val("ignore.cout", 32'(cout), 32'd0);
    check_val("ignore.ovf", 32'(ovf), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_val("ignore.back_idle", 32'(in_ready), 32'd1);
    $display("add ignore: a=0f b=01 cin=0 with stray f0+f0 -> sum=%02h", sum);

    // Abort at idx=3
    op_a = 8'hAA; op_b = 8'h55; carry_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("abort.in_ready", 32'(in_ready), 32'd1);
    check_val("abort.busy", 32'(busy), 32'd0);
    check_val("abort.res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("abort.no_result", 32'(res_valid), 32'd0);
    end
    $display("abort: aa+55 cancelled at idx=3, in_ready=%0d", in_ready);

    // Asynchronous reset between edges mid-RUN
    op_a = 8'hFF; op_b = 8'h00; carry_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_val("arst.partial_sum", 32'(sum), 32'h07);
    #2 rstn = 1'b0;
    #1;
    check_val("arst.in_ready", 32'(in_ready), 32'd1);
    check_val("arst.busy", 32'(busy), 32'd0);
    check_val("arst.res_valid", 32'(res_valid), 32'd0);
    check_val("arst.sum", 32'(sum), 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check_val("arst.idle_after", 32'(in_ready), 32'd1);
    $display("async reset mid-run: sum=%02h busy=%0d", sum, busy);

    // Back-to-back adds with res_ready tied high
    first_res = -1;
    second_res = -1;
    op_a = 8'h12; op_b = 8'h34; carry_in = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (cyc == 39) begin
        in_valid = 1'b0;
        res_ready = 1'b0;
      end
      if (res_valid) begin
        check_val("b2b.sum", 32'(sum), 32'h47);
        if (first_res < 0) first_res = cyc;
        else if (second_res < 0) second_res = cyc;
      end
    end
    check_val("b2b.first_latency", 32'(first_res), 32'd8);
    check_val("b2b.period", 32'(second_res - first_res), 32'd10);
    for (int i = 0; i < 12; i++) step();
    check_val("b2b.final_idle", 32'(in_ready), 32'd1);
    $display("back-to-back: first result at cycle %0d, period %0d", first_res, second_res - first_res);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
